// File: rtl/z2_cycle_fsm_pkg.sv
// Shared definitions for the Zorro II bus-cycle sequencer.
// The z2_state encoding is also decoded by the autoconfig and RAM controller blocks.
package z2_cycle_fsm_pkg;

  typedef enum logic [1:0] {
    Z2Idle  = 2'b00,
    Z2Start = 2'b01,
    Z2Data  = 2'b10,
    Z2End   = 2'b11
  } z2_state_e;

  localparam int unsigned MinSyncStages    = 2;
  localparam int unsigned MinTimeoutCycles = 2;

  // Any of the three decode regions claims the cycle for this board.
  function automatic logic decode_hit(input logic ram_access, input logic ctrl_access,
                                      input logic autoconfig_cycle);
    return ram_access | ctrl_access | autoconfig_cycle;
  endfunction

endpackage

// File: rtl/z2_cycle_fsm_sync_ff.sv
// Multi-stage synchroniser for an asynchronous active-low strobe; every stage resets to 1
// so a reset looks like "strobe released".
module z2_cycle_fsm_sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_d, sync_q;

  // Shift the pin sample in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  // Synchroniser flops, asynchronously forced high by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/z2_cycle_fsm.sv
// Zorro II bus-cycle sequencer: synchronises AS_n and the data strobes, walks the
// IDLE/START/DATA/END phases, latches direction and byte lanes, and times DTACK.
// Optional feature macro: Z2_TIMEOUT_EN adds a forced acknowledge after TIMEOUT_CYCLES-1
// edges in Z2_DATA.
module z2_cycle_fsm
  import z2_cycle_fsm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       ram_access,
  input  logic       ctrl_access,
  input  logic       autoconfig_cycle,
  input  logic       dev_ack,
  output logic [1:0] z2_state,
  output logic       cycle_rw,
  output logic [1:0] byte_en,
  output logic       DTACK_n,
  output logic       DTACK_OE,
  output logic       timeout
);

  if (SYNC_STAGES < MinSyncStages || TIMEOUT_CYCLES < MinTimeoutCycles) begin : g_param_check
    $error("z2_cycle_fsm: SYNC_STAGES and TIMEOUT_CYCLES must both be at least 2");
  end

  logic as_sync, ds_sync;

  z2_cycle_fsm_sync_ff #(
    .Stages(SYNC_STAGES)
  ) u_sync_as (
    .clk_i(CLK),
    .rst_i(RESET),
    .d_i  (AS_n),
    .q_o  (as_sync)
  );

  // A data strobe counts as asserted once either lane is asserted.
  z2_cycle_fsm_sync_ff #(
    .Stages(SYNC_STAGES)
  ) u_sync_ds (
    .clk_i(CLK),
    .rst_i(RESET),
    .d_i  (UDS_n & LDS_n),
    .q_o  (ds_sync)
  );

  z2_state_e  state_d, state_q;
  logic       cycle_rw_d, cycle_rw_q;
  logic [1:0] byte_en_d, byte_en_q;
  logic       dtack_oe_d, dtack_oe_q;
  logic       dtack_n_d, dtack_n_q;
  logic       timeout_d, timeout_q;
  // Set only after AS was seen released in idle; blocks re-entry on a held AS and makes
  // decode inputs count only at the first low AS sample of a cycle.
  logic       armed_d, armed_q;

`ifdef Z2_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_d, cnt_q, cnt_inc;

  // Saturating count of edges spent in Z2_DATA.
  always_comb begin
    cnt_inc = (cnt_q == CntLast) ? cnt_q : cnt_q + 1'b1;
  end
`endif

  // Phase sequencing and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    cycle_rw_d = cycle_rw_q;
    byte_en_d  = byte_en_q;
    dtack_oe_d = dtack_oe_q;
    timeout_d  = 1'b0;
    armed_d    = 1'b0;
`ifdef Z2_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      Z2Idle: begin
        armed_d = as_sync;
        if (armed_q && !as_sync && decode_hit(ram_access, ctrl_access, autoconfig_cycle)) begin
          state_d    = Z2Start;
          cycle_rw_d = RW;
        end
      end
      Z2Start: begin
        if (as_sync) begin
          state_d = Z2Idle;
        end else if (!ds_sync) begin
          state_d   = Z2Data;
          byte_en_d = {~UDS_n, ~LDS_n};
`ifdef Z2_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      Z2Data: begin
`ifdef Z2_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        // Abort outranks both the real and the forced acknowledge.
        if (as_sync) begin
          state_d = Z2Idle;
        end else if (dev_ack) begin
          state_d    = Z2End;
          dtack_oe_d = 1'b1;
`ifdef Z2_TIMEOUT_EN
        end else if (cnt_inc == CntLast) begin
          state_d    = Z2End;
          dtack_oe_d = 1'b1;
          timeout_d  = 1'b1;
`endif
        end
      end
      Z2End: begin
        if (as_sync) begin
          state_d    = Z2Idle;
          dtack_oe_d = 1'b0;
        end
      end
      default: begin
        state_d    = Z2Idle;
        dtack_oe_d = 1'b0;
      end
    endcase
    dtack_n_d = ~dtack_oe_d;
  end

  // Single state register holding the FSM and every registered output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= Z2Idle;
      cycle_rw_q <= 1'b1;
      byte_en_q  <= 2'b00;
      dtack_oe_q <= 1'b0;
      dtack_n_q  <= 1'b1;
      timeout_q  <= 1'b0;
      armed_q    <= 1'b0;
`ifdef Z2_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cycle_rw_q <= cycle_rw_d;
      byte_en_q  <= byte_en_d;
      dtack_oe_q <= dtack_oe_d;
      dtack_n_q  <= dtack_n_d;
      timeout_q  <= timeout_d;
      armed_q    <= armed_d;
`ifdef Z2_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign z2_state = state_q;
  assign cycle_rw = cycle_rw_q;
  assign byte_en  = byte_en_q;
  assign DTACK_OE = dtack_oe_q;
  assign DTACK_n  = dtack_n_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_z2_cycle_fsm.sv
// Self-checking bench for z2_cycle_fsm: a per-cycle reference model of the bus phases plus
// directed cycles with hand-counted edge latencies. Honours Z2_TIMEOUT_EN.
module tb_z2_cycle_fsm;

  localparam int Sync    = 2;
  localparam int Timeout = 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       AS_n, UDS_n, LDS_n, RW;
  logic       ram_access, ctrl_access, autoconfig_cycle, dev_ack;
  logic [1:0] z2_state;
  logic       cycle_rw;
  logic [1:0] byte_en;
  logic       DTACK_n, DTACK_OE, timeout;

  int checks = 0;
  int errors = 0;

  z2_cycle_fsm #(
    .SYNC_STAGES   (Sync),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .AS_n            (AS_n),
    .UDS_n           (UDS_n),
    .LDS_n           (LDS_n),
    .RW              (RW),
    .ram_access      (ram_access),
    .ctrl_access     (ctrl_access),
    .autoconfig_cycle(autoconfig_cycle),
    .dev_ack         (dev_ack),
    .z2_state        (z2_state),
    .cycle_rw        (cycle_rw),
    .byte_en         (byte_en),
    .DTACK_n         (DTACK_n),
    .DTACK_OE        (DTACK_OE),
    .timeout         (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pin history gives the synchronised view; phase is a plain integer.
  int         m_phase = 0;
  logic       m_rw = 1'b1;
  logic [1:0] m_be = 2'b00;
  logic       m_to = 1'b0;
  logic       m_prev_high = 1'b0;
  int         m_wait = 0;
  logic       as_hist [Sync];
  logic       ds_hist [Sync];

  function automatic logic [7:0] model_vec();
    logic oe;
    logic [1:0] ph;
    oe = (m_phase == 3);
    ph = 2'(m_phase);
    return {ph, m_rw, m_be, ~oe, oe, m_to};
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase = 0; m_rw = 1'b1; m_be = 2'b00; m_to = 1'b0; m_prev_high = 1'b0; m_wait = 0;
      for (int i = 0; i < Sync; i++) begin
        as_hist[i] = 1'b1;
        ds_hist[i] = 1'b1;
      end
    end else begin
      logic as_s, ds_s, was_idle;
      as_s = as_hist[Sync-1];
      ds_s = ds_hist[Sync-1];
      was_idle = (m_phase == 0);
      m_to = 1'b0;
      case (m_phase)
        0: if (m_prev_high && !as_s && (ram_access || ctrl_access || autoconfig_cycle)) begin
          m_phase = 1;
          m_rw = RW;
        end
        1: if (as_s) m_phase = 0;
           else if (!ds_s) begin
             m_phase = 2;
             m_be = {~UDS_n, ~LDS_n};
             m_wait = 0;
           end
        2: if (as_s) m_phase = 0;
           else if (dev_ack) m_phase = 3;
           else begin
             m_wait++;
`ifdef Z2_TIMEOUT_EN
             if (m_wait == Timeout - 1) begin
               m_phase = 3;
               m_to = 1'b1;
             end
`endif
           end
        default: if (as_s) m_phase = 0;
      endcase
      m_prev_high = was_idle && as_s;
      for (int i = Sync - 1; i > 0; i--) begin
        as_hist[i] = as_hist[i-1];
        ds_hist[i] = ds_hist[i-1];
      end
      as_hist[0] = AS_n;
      ds_hist[0] = UDS_n & LDS_n;
      #1;
      check("cycle", {24'd0, z2_state, cycle_rw, byte_en, DTACK_n, DTACK_OE, timeout},
            {24'd0, model_vec()});
    end
  end

  // Count edges until z2_state equals st; an expired budget is a failed comparison.
  task automatic wait_state(input logic [1:0] st, input int budget, output int n);
    n = 0;
    while (1) begin
      @(posedge CLK);
      #2;
      n++;
      if (z2_state == st) return;
      if (n >= budget) begin
        check("wait_state_budget", {30'd0, z2_state}, {30'd0, st});
        return;
      end
    end
  endtask

  task automatic bus_idle();
    AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    ram_access = 1'b0; ctrl_access = 1'b0; autoconfig_cycle = 1'b0; dev_ack = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    RESET = 1'b1;
    RW = 1'b1;
    bus_idle();
    #1;
    check("reset_vec", {24'd0, z2_state, cycle_rw, byte_en, DTACK_n, DTACK_OE, timeout},
          32'h24);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    // Read hit, both lanes.
    RW = 1'b1; ram_access = 1'b1; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
    wait_state(2'b01, 10, n); check("read_start_edges", n, 3);
    wait_state(2'b10, 10, n); check("read_data_edges", n, 1);
    repeat (4) @(negedge CLK);
    dev_ack = 1'b1;
    wait_state(2'b11, 10, n); check("read_end_edges", n, 1);
    check("read_dtack", {30'd0, DTACK_OE, DTACK_n}, 32'h2);
    check("read_rw_be", {29'd0, cycle_rw, byte_en}, 32'h7);
    @(negedge CLK);
    bus_idle();
    wait_state(2'b00, 10, n); check("read_release_edges", n, 3);
    check("read_dtack_off", {30'd0, DTACK_OE, DTACK_n}, 32'h1);
    repeat (3) @(negedge CLK);

    // Write, lower byte only, data strobe late.
    RW = 1'b0; ram_access = 1'b1; AS_n = 1'b0;
    wait_state(2'b01, 10, n); check("write_start_edges", n, 3);
    @(negedge CLK);
    LDS_n = 1'b0;
    wait_state(2'b10, 10, n); check("write_data_edges", n, 3);
    @(negedge CLK);
    dev_ack = 1'b1;
    wait_state(2'b11, 10, n);
    check("write_rw_be", {29'd0, cycle_rw, byte_en}, 32'h1);
    @(negedge CLK);
    bus_idle();
    wait_state(2'b00, 10, n);
    repeat (3) @(negedge CLK);

    // Abort coinciding with dev_ack.
    RW = 1'b1; ram_access = 1'b1; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
    wait_state(2'b10, 10, n);
    @(negedge CLK);
    AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    dev_ack = 1'b1;
    wait_state(2'b00, 10, n); check("abort_edges", n, 1);
    check("abort_dtack", {30'd0, DTACK_OE, DTACK_n}, 32'h1);
    @(negedge CLK);
    bus_idle();
    repeat (3) @(negedge CLK);

    // Miss: no decode hit; a late decode change inside the cycle is ignored.
    AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 10) ctrl_access = 1'b1;
      if (z2_state != 2'b00 || DTACK_OE != 1'b0) bad++;
    end
    check("miss_cycles_claimed", bad, 0);
    bus_idle();
    repeat (3) @(negedge CLK);

    // No acknowledge: forced END with the timeout feature, otherwise an indefinite wait.
    autoconfig_cycle = 1'b1; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
    wait_state(2'b01, 10, n);
    wait_state(2'b10, 10, n);
`ifdef Z2_TIMEOUT_EN
    wait_state(2'b11, 20, n); check("timeout_edges", n, 7);
    check("timeout_pulse", {31'd0, timeout}, 32'd1);
    check("timeout_dtack", {31'd0, DTACK_OE}, 32'd1);
    @(posedge CLK);
    #2;
    check("timeout_pulse_end", {31'd0, timeout}, 32'd0);
    @(negedge CLK);
    bus_idle();
    wait_state(2'b00, 10, n); check("timeout_release_edges", n, 3);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (z2_state != 2'b10 || DTACK_OE != 1'b0 || timeout != 1'b0) bad++;
    end
    check("no_timeout_hold", bad, 0);
    bus_idle();
    wait_state(2'b00, 10, n); check("no_timeout_abort_edges", n, 3);
`endif
    repeat (3) @(negedge CLK);

    // Reset pulse while in END, between clock edges.
    RW = 1'b0; ram_access = 1'b1; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
    wait_state(2'b10, 10, n);
    @(negedge CLK);
    dev_ack = 1'b1;
    wait_state(2'b11, 10, n);
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    bus_idle();
    #1;
    check("midcycle_reset_vec",
          {24'd0, z2_state, cycle_rw, byte_en, DTACK_n, DTACK_OE, timeout}, 32'h24);
    #1;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    // Normal cycle after the reset.
    RW = 1'b1; ctrl_access = 1'b1; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b1;
    wait_state(2'b01, 10, n); check("post_reset_start_edges", n, 3);
    wait_state(2'b10, 10, n); check("post_reset_data_edges", n, 1);
    @(negedge CLK);
    dev_ack = 1'b1;
    wait_state(2'b11, 10, n);
    check("post_reset_rw_be", {29'd0, cycle_rw, byte_en}, 32'h6);
    @(negedge CLK);
    bus_idle();
    wait_state(2'b00, 10, n); check("post_reset_release_edges", n, 3);
    repeat (3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
